// File: rtl/ofmd_wr_addr_gen.sv
// ofmd_wr_addr_gen: OFMD SRAM write-address generator.
// Walks col/row/chan for each conv result; LAT-deep write pipe.
module ofmd_wr_addr_gen #(
  parameter int ADDR_WIDTH = 6,
  parameter int DIM_WIDTH  = 4,
  parameter int CH_WIDTH   = 2,
  parameter int LAT        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  cfg_cols,
  input  logic [DIM_WIDTH-1:0]  cfg_rows,
  input  logic [CH_WIDTH-1:0]   cfg_chans,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_pitch,
  input  logic [ADDR_WIDTH-1:0] cfg_plane,
  input  logic                  pix_vld,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [CH_WIDTH-1:0]   wr_ch,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;

  logic [DIM_WIDTH-1:0]  cols_q;
  logic [DIM_WIDTH-1:0]  rows_q;
  logic [CH_WIDTH-1:0]   chans_q;
  logic [ADDR_WIDTH-1:0] pitch_q;
  logic [ADDR_WIDTH-1:0] plane_q;

  logic [DIM_WIDTH-1:0]  col;
  logic [DIM_WIDTH-1:0]  row;
  logic [CH_WIDTH-1:0]   ch;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] ch_base;

  logic [LAT-1:0]        pv;
  logic [ADDR_WIDTH-1:0] pa [LAT];
  logic [CH_WIDTH-1:0]   pc [LAT];

  logic                  push;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic                  last_col;
  logic                  last_row;
  logic                  last_ch;
  logic                  pend;

  assign push      = (state == RUN) && pix_vld;
  assign push_addr = row_base + ADDR_WIDTH'(col);
  assign last_col  = (col == cols_q - DIM_WIDTH'(1));
  assign last_row  = (row == rows_q - DIM_WIDTH'(1));
  assign last_ch   = (ch == chans_q - CH_WIDTH'(1));

  assign wr_en   = pv[LAT-1];
  assign wr_addr = pa[LAT-1];
  assign wr_ch   = pc[LAT-1];

  // Entries still ahead of the output stage after this shift
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      pend = pend | pv[i];
    end
  end

  // Frame sequencer: config latch, col/row/chan walk, busy/done
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cols_q   <= '0;
      rows_q   <= '0;
      chans_q  <= '0;
      pitch_q  <= '0;
      plane_q  <= '0;
      col      <= '0;
      row      <= '0;
      ch       <= '0;
      row_base <= '0;
      ch_base  <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            cols_q   <= cfg_cols;
            rows_q   <= cfg_rows;
            chans_q  <= cfg_chans;
            pitch_q  <= cfg_pitch;
            plane_q  <= cfg_plane;
            col      <= '0;
            row      <= '0;
            ch       <= '0;
            row_base <= cfg_base;
            ch_base  <= cfg_base;
            if (cfg_cols == '0 || cfg_rows == '0 ||
                cfg_chans == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pix_vld) begin
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row      <= '0;
                ch       <= ch + CH_WIDTH'(1);
                ch_base  <= ch_base + plane_q;
                row_base <= ch_base + plane_q;
                if (last_ch) begin
                  state <= DRAIN;
                end
              end else begin
                row      <= row + DIM_WIDTH'(1);
                row_base <= row_base + pitch_q;
              end
            end else begin
              col <= col + DIM_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (!pend) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Write delay pipe; addr/ch stages only load on valid entries
  always_ff @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) begin
        pa[i] <= '0;
        pc[i] <= '0;
      end
    end else if (en) begin
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pa[i] <= pa[i-1];
          pc[i] <= pc[i-1];
        end
      end
      pv[0] <= push;
      if (push) begin
        pa[0] <= push_addr;
        pc[0] <= ch;
      end
    end
  end

endmodule
